// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the reciprocal frequency-meter sequencer.
// The autorange thresholds only take effect when FREQ_AUTORANGE_EN is defined.
package freq_meter_pkg;

  localparam int CNT_W_DEF  = 48;
  localparam int FREQ_W_DEF = 32;

  localparam int unsigned AR_LONG_BELOW  = 1000;
  localparam int unsigned AR_NORMAL_FROM = 4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_GATE,
    ST_WAIT_CNT,
    ST_DIVIDE
  } meas_state_e;

  function automatic logic want_long_gate(input logic [63:0] cnt_test);
    return cnt_test < 64'(AR_LONG_BELOW);
  endfunction

  function automatic logic want_normal_gate(input logic [63:0] cnt_test);
    return cnt_test >= 64'(AR_NORMAL_FROM);
  endfunction

endpackage

// File: rtl/freq_div_seq.sv
// Restoring unsigned divider: one quotient bit per cycle, NUM_W cycles per divide.
// done pulses together with the final quotient bit; ovf flags a quotient wider than Q_W.
module freq_div_seq #(
  parameter int NUM_W = 80,
  parameter int DEN_W = 48,
  parameter int Q_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic             ovf
);

  localparam int CNT_BITS = $clog2(NUM_W + 1);

  logic [DEN_W-1:0]    rem_q, rem_d;
  logic [DEN_W-1:0]    den_q, den_d;
  logic [NUM_W-1:0]    quo_q, quo_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DEN_W:0]      trial;
  logic [DEN_W-1:0]    diff;
  logic                q_bit;

  // quo_q starts as the numerator and shifts quotient bits in from the right.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    trial  = {rem_q, quo_q[NUM_W-1]};
    q_bit  = (trial >= {1'b0, den_q});
    diff   = trial[DEN_W-1:0] - den_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = '0;
      den_d  = divisor;
      quo_d  = numerator;
      cnt_d  = CNT_BITS'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = q_bit ? diff : trial[DEN_W-1:0];
      quo_d = {quo_q[NUM_W-2:0], q_bit};
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: datapath registers are reset as well, so a reset mid-divide leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q[Q_W-1:0];
  assign ovf      = |quo_q[NUM_W-1:Q_W];

endmodule

// File: rtl/freq_meas_ctrl.sv
// Reciprocal frequency-meter sequencer: gate generation, count capture, sequential divide.
// Define FREQ_AUTORANGE_EN to switch between a normal and a 4x gate based on the last count.
module freq_meas_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 48_000_000,
  parameter int unsigned PREP_CYC = 12_000_000,
  parameter int unsigned GATE_CYC = 48_000_000,
  parameter int unsigned WAIT_MAX = 1_000_000,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int          FREQ_W   = FREQ_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  output logic              gate_s,
  input  logic              cnt_valid,
  input  logic [CNT_W-1:0]  cnt_test,
  input  logic [CNT_W-1:0]  cnt_stand,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              busy,
  output logic              err
);

  localparam int NUM_W = CNT_W + 32;

  meas_state_e       state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              gate_q, gate_d;
  logic              fv_q, fv_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [31:0]       gate_len;
  logic              enter_prep;
  logic              div_start, div_busy, div_done, div_ovf;
  logic [FREQ_W-1:0] div_quot;
  logic [NUM_W-1:0]  numerator;

  // Multiply before divide keeps full resolution of the reciprocal result.
  assign numerator = NUM_W'(cnt_test) * NUM_W'(CLK_HZ);

`ifdef FREQ_AUTORANGE_EN
  logic long_q, long_d, seen_q, seen_d, last_lo_q, last_lo_d, last_hi_q, last_hi_d;
  assign gate_len = long_q ? 32'(4 * GATE_CYC) : 32'(GATE_CYC);
`else
  assign gate_len = 32'(GATE_CYC);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    gate_d     = 1'b0;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    zero_d     = zero_q;
    freq_d     = freq_q;
    div_start  = 1'b0;
    enter_prep = 1'b0;
`ifdef FREQ_AUTORANGE_EN
    seen_d    = seen_q;
    last_lo_d = last_lo_q;
    last_hi_d = last_hi_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        enter_prep = run;
      end
      ST_PREP: begin
        if (cnt_q == 32'(PREP_CYC - 1)) begin
          state_d = ST_GATE;
          cnt_d   = '0;
          gate_d  = 1'b1;
        end
      end
      ST_GATE: begin
        if (cnt_q == gate_len - 32'd1) begin
          state_d = ST_WAIT_CNT;
          cnt_d   = '0;
        end else begin
          gate_d = 1'b1;
        end
      end
      ST_WAIT_CNT: begin
        if (cnt_valid && !div_busy) begin
          state_d   = ST_DIVIDE;
          zero_d    = (cnt_stand == '0);
          div_start = (cnt_stand != '0);
`ifdef FREQ_AUTORANGE_EN
          seen_d    = 1'b1;
          last_lo_d = want_long_gate(64'(cnt_test));
          last_hi_d = want_normal_gate(64'(cnt_test));
`endif
        end else if (cnt_q == 32'(WAIT_MAX - 1)) begin
          err_d      = 1'b1;
          state_d    = ST_IDLE;
          enter_prep = run;
        end
      end
      ST_DIVIDE: begin
        if (zero_q || div_done) begin
          fv_d       = 1'b1;
          err_d      = zero_q | div_ovf;
          state_d    = ST_IDLE;
          enter_prep = run;
          if (zero_q)       freq_d = '0;
          else if (div_ovf) freq_d = '1;
          else              freq_d = div_quot;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_prep) begin
      state_d = ST_PREP;
      cnt_d   = '0;
    end
    busy_d = (state_d != ST_IDLE);
`ifdef FREQ_AUTORANGE_EN
    long_d = long_q;
    if (enter_prep && seen_q) begin
      if (last_lo_q)      long_d = 1'b1;
      else if (last_hi_q) long_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b0;
      freq_q  <= '0;
`ifdef FREQ_AUTORANGE_EN
      long_q    <= 1'b0;
      seen_q    <= 1'b0;
      last_lo_q <= 1'b0;
      last_hi_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
      freq_q  <= freq_d;
`ifdef FREQ_AUTORANGE_EN
      long_q    <= long_d;
      seen_q    <= seen_d;
      last_lo_q <= last_lo_d;
      last_hi_q <= last_hi_d;
`endif
    end
  end

  freq_div_seq #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W),
    .Q_W   (FREQ_W)
  ) u_div (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .start     (div_start),
    .numerator (numerator),
    .divisor   (cnt_stand),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .ovf       (div_ovf)
  );

  assign gate_s     = gate_q;
  assign freq       = freq_q;
  assign freq_valid = fv_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with CLK_HZ=1000, PREP_CYC=4, GATE_CYC=100, WAIT_MAX=50.
module tb_freq_meas_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        run;
  logic        cnt_valid;
  logic [47:0] cnt_test;
  logic [47:0] cnt_stand;
  logic        gate_s;
  logic [31:0] freq;
  logic        freq_valid;
  logic        busy;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  freq_meas_ctrl #(
    .CLK_HZ   (1000),
    .PREP_CYC (4),
    .GATE_CYC (100),
    .WAIT_MAX (50)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .run        (run),
    .gate_s     (gate_s),
    .cnt_valid  (cnt_valid),
    .cnt_test   (cnt_test),
    .cnt_stand  (cnt_stand),
    .freq       (freq),
    .freq_valid (freq_valid),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Returns at the first negedge after gate_s falls (FSM sits in WAIT_CNT, counter 0).
  task automatic wait_gate_fall();
    int n;
    n = 0;
    while (!gate_s && n < 500) begin step(1); n++; end
    check("gate_rise_seen", 64'(gate_s), 64'd1);
    n = 0;
    while (gate_s && n < 500) begin step(1); n++; end
    check("gate_fall_seen", 64'(gate_s), 64'd0);
  endtask

  task automatic measure(input logic [47:0] t, input logic [47:0] s, output int lat);
    cnt_test  = t;
    cnt_stand = s;
    cnt_valid = 1'b1;
    step(1);
    cnt_valid = 1'b0;
    lat = 0;
    while (!freq_valid && lat < 200) begin step(1); lat++; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    int fv_cnt;
    logic fv_seen;

    run = 1'b0; cnt_valid = 1'b0; cnt_test = '0; cnt_stand = '0; sys_rst_n = 1'b0;
    step(2);
    check("rst_gate_s", 64'(gate_s), 64'd0);
    check("rst_freq_valid", 64'(freq_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_freq", 64'(freq), 64'd0);
    sys_rst_n = 1'b1;
    step(2);
    check("idle_busy", 64'(busy), 64'd0);

    // Gate timing: rise 5 cycles after run, high for 100 cycles.
    run = 1'b1;
    step(4);
    check("prep_gate_low", 64'(gate_s), 64'd0);
    check("prep_busy", 64'(busy), 64'd1);
    step(1);
    check("gate_rise_at_5", 64'(gate_s), 64'd1);
    n = 0;
    while (gate_s && n < 300) begin n++; step(1); end
    check("gate_high_cycles", 64'(n), 64'd100);

    // Basic: 1000*50/100 = 500.
    measure(48'd50, 48'd100, lat);
    check("basic_latency", 64'(lat), 64'd81);
    check("basic_freq", 64'(freq), 64'd500);
    check("basic_err", 64'(err), 64'd0);
    step(1);
    check("basic_fv_pulse", 64'(freq_valid), 64'd0);
    check("basic_freq_hold", 64'(freq), 64'd500);

    // Truncation: 1000/3 = 333.
    wait_gate_fall();
    measure(48'd1, 48'd3, lat);
    check("trunc_latency", 64'(lat), 64'd81);
    check("trunc_freq", 64'(freq), 64'd333);
    check("trunc_err", 64'(err), 64'd0);

    // cnt_stand == 0: result one cycle after capture.
    wait_gate_fall();
    measure(48'd5, 48'd0, lat);
    check("zero_latency", 64'(lat), 64'd1);
    check("zero_freq", 64'(freq), 64'd0);
    check("zero_err", 64'(err), 64'd1);

    // Overflow: 1000*2^40 saturates.
    wait_gate_fall();
    measure(48'h0100_0000_0000, 48'd1, lat);
    check("ovf_latency", 64'(lat), 64'd81);
    check("ovf_freq", 64'(freq), 64'hFFFF_FFFF);
    check("ovf_err", 64'(err), 64'd1);

    // Timeout: err 50 cycles after gate falls, no freq_valid, next PREP follows.
    wait_gate_fall();
    n = 0;
    fv_seen = 1'b0;
    while (!err && n < 200) begin
      step(1);
      n++;
      if (freq_valid) fv_seen = 1'b1;
    end
    check("timeout_cycles", 64'(n), 64'd50);
    check("timeout_no_fv", 64'(fv_seen), 64'd0);
    check("timeout_freq_kept", 64'(freq), 64'hFFFF_FFFF);
    check("timeout_busy", 64'(busy), 64'd1);
    step(1);
    check("timeout_err_pulse", 64'(err), 64'd0);
    n = 0;
    while (!gate_s && n < 50) begin step(1); n++; end
    check("timeout_next_gate", 64'(n), 64'd3);

    // run dropped during GATE: one more result, then IDLE.
    step(10);
    check("stop_in_gate", 64'(gate_s), 64'd1);
    run = 1'b0;
    wait_gate_fall();
    measure(48'd7, 48'd1, lat);
    check("stop_latency", 64'(lat), 64'd81);
    check("stop_freq", 64'(freq), 64'd7000);
    check("stop_busy_low", 64'(busy), 64'd0);
    fv_cnt = 0;
    fv_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (freq_valid) fv_cnt++;
      if (gate_s) fv_seen = 1'b1;
    end
    check("stop_no_more_fv", 64'(fv_cnt), 64'd0);
    check("stop_no_more_gate", 64'(fv_seen), 64'd0);
    check("stop_idle_busy", 64'(busy), 64'd0);

    // Reset asserted while dividing.
    run = 1'b1;
    wait_gate_fall();
    cnt_test = 48'd50; cnt_stand = 48'd100; cnt_valid = 1'b1;
    step(1);
    cnt_valid = 1'b0;
    step(20);
    check("div_busy_before_rst", 64'(busy), 64'd1);
    run = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_gate_s", 64'(gate_s), 64'd0);
    check("mid_rst_freq_valid", 64'(freq_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_freq", 64'(freq), 64'd0);
    step(2);
    sys_rst_n = 1'b1;
    fv_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (freq_valid) fv_cnt++;
    end
    check("post_rst_no_fv", 64'(fv_cnt), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Fresh measurement after the mid-divide reset.
    run = 1'b1;
    wait_gate_fall();
    run = 1'b0;
    measure(48'd1, 48'd3, lat);
    check("post_rst_latency", 64'(lat), 64'd81);
    check("post_rst_freq", 64'(freq), 64'd333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
